sinerom_osc: RTL and testbench
==============================

// Module: sinerom_osc
// PURPOSE
//  Initiator for the 1024x16 sine ROM (active-low cs, registered read, 1-cycle latency, z_oe qualifies data).
//  Runs a phase accumulator, fetches ROM samples by phase[PHW-1:PHW-10], scales them by an amplitude and queues
//  the results in a 2-entry output FIFO with a valid/ready handshake. Feeds DSP-side audio/test-tone logic.
//  Shares the ROM with other initiators through bus_req/bus_gnt.
// PARAMETERS
//  PHW     22  phase accumulator width; top 10 bits form the ROM address, the rest is fraction
//  DEPTH   2   output FIFO entries (fixed at 2; parameter exists for assertions only)
// PORTS
//  sys_clk     in   1      single clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  en          in   1      1 = oscillator runs; 0 = stop issuing new reads (in-flight read completes)
//  phase_inc   in   PHW    phase increment added per fetched sample
//  phase_ld    in   1      pulse: phase <= phase_init (takes priority over increment)
//  phase_init  in   PHW    load value for phase
//  amp         in   16     signed Q1.15 amplitude; sampled when the ROM data is captured
//  bus_req     out  1      request for the shared ROM
//  bus_gnt     in   1      grant; cs may only be asserted while bus_gnt=1
//  cs          out  1      ROM chip select, active low
//  a           out  [0:9]  ROM address, a[0] = LSB
//  z_in        in   [0:15] ROM data, z_in[0] = LSB
//  z_oe        in   [0:15] ROM output enables; all-ones marks valid data
//  smp         out  16     signed scaled sample (FIFO head)
//  smp_valid   out  1      FIFO non-empty
//  smp_ready   in   1      consumer accepts smp when smp_valid & smp_ready
//  err         out  1      sticky: ROM data not valid in capture cycle; cleared only by reset
// BEHAVIOUR
//  Reset: phase=0, state IDLE, cs=1, a=0, bus_req=0, FIFO empty, smp=0, smp_valid=0, err=0.
//  FSM: IDLE -> REQ when en & free FIFO slots beyond in-flight (count+inflight < 2); bus_req=1 in REQ.
//   REQ: when bus_gnt=1: cs=0 for exactly one cycle, a=phase[PHW-1:PHW-10]; phase += phase_inc (mod 2^PHW) in same
//   cycle -> CAP. If bus_gnt=0 stay in REQ, cs=1, phase unchanged. en dropping in REQ -> IDLE without a read.
//   CAP (cycle after cs=0): if z_oe==16'hffff capture z_in, start MUL; else set err, discard, no FIFO write.
//   Next state from CAP: REQ if en & slot available (back-to-back reads, 1 read per 2 cycles), else IDLE.
//  MUL stage: prod = $signed(z) * $signed(amp) (32b); result = prod[30:15], saturate 0x8000*0x8000 to 0x7fff.
//   Result written to FIFO one cycle after CAP. Capture-to-smp_valid latency: 2 cycles from CAP cycle.
//  Slot accounting: a read counts against FIFO space from the REQ grant cycle until its FIFO write or err drop.
//  FIFO: write and pop in same cycle when full is legal (count unchanged); pop on empty ignored; smp is the
//   registered head, stable while smp_valid & ~smp_ready.
//  phase_ld: overrides the phase update in any state, including the grant cycle (address already issued uses old
//   phase). Does not flush FIFO.
//  Phase wrap: natural modulo 2^PHW; address wraps 1023 -> 0.
//  reset mid-read: all state cleared next edge; cs forced to 1; late ROM data ignored.
// STRUCTURE
//  Package sinerom_pkg: ROM_AW=10, ROM_DW=16, OE_ALL=16'hffff, FSM state enum {IDLE,REQ,CAP}.
//  Sub-module: sinerom_osc_fifo (2-entry valid/ready FIFO, 16b). Multiplier inline.
// TESTING
//  Reset then en=1, inc=1<<12, gnt=1, amp=0x7fff -> a=0,1,2,... every 2nd cycle, smp=rom[n]*0x7fff>>15 in order.
//  smp_ready=0 with en=1 -> exactly 2 reads issued, then cs stays 1, bus_req=0; ready=1 resumes, no sample lost.
//  bus_gnt held 0 for 5 cycles -> bus_req=1, cs=1, phase frozen; gnt=1 -> one cs pulse at held address.
//  phase_init=0x3FF000 load, inc=0x1000 -> addresses 1023 then 0 (wrap).
//  ROM model drives z_oe=0 in capture cycle -> err=1 sticky, no FIFO write, next read proceeds normally.
//  amp=0x8000, rom value 0x8000 -> smp=0x7fff; reset asserted in CAP -> smp_valid=0, cs=1 next cycle.

Source files
------------

// File: rtl/sinerom_pkg.sv
// -----------------------------------------------------------------------------
// sinerom_pkg
// Shared constants and types for the sine-ROM oscillator.
//   ROM_AW / ROM_DW : geometry of the shared 1024x16 sine ROM
//   OE_ALL          : z_oe pattern that marks valid ROM data
//   state_t         : read-sequencer FSM states
// -----------------------------------------------------------------------------
package sinerom_pkg;

  localparam int ROM_AW = 10;
  localparam int ROM_DW = 16;
  localparam logic [ROM_DW-1:0] OE_ALL = 16'hffff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } state_t;

endpackage

// File: rtl/sinerom_osc_fifo.sv
// -----------------------------------------------------------------------------
// sinerom_osc_fifo
// Two-entry valid/ready FIFO. The head entry is a register, so o_data is
// stable while o_valid is high and i_ready is low.
// Ports:
//   clk, srst          : clock, synchronous active-high reset
//   i_push, i_data     : write strobe and data (caller guarantees space)
//   i_ready            : consumer ready; pop = i_ready & o_valid
//   o_data, o_valid    : registered head entry and non-empty flag
//   o_pop              : a pop happens on this edge
//   o_count            : current number of stored entries (0..2)
// -----------------------------------------------------------------------------
module sinerom_osc_fifo
  import sinerom_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_push,
  input  logic [ROM_DW-1:0] i_data,
  input  logic              i_ready,
  output logic [ROM_DW-1:0] o_data,
  output logic              o_valid,
  output logic              o_pop,
  output logic [1:0]        o_count
);

  logic [ROM_DW-1:0] r_mem [2];
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_full;

  assign w_pop   = i_ready && (r_count != 2'd0);
  assign w_full  = (r_count == 2'd2);
  assign o_data  = r_mem[0];
  assign o_valid = (r_count != 2'd0);
  assign o_pop   = w_pop;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (i_push && w_pop) begin
      // Simultaneous write and pop: occupancy unchanged, queue shifts.
      if (r_count == 2'd1) begin
        r_mem[0] <= i_data;
      end else begin
        r_mem[0] <= r_mem[1];
        r_mem[1] <= i_data;
      end
    end else if (i_push && !w_full) begin
      if (r_count == 2'd0) begin
        r_mem[0] <= i_data;
      end else begin
        r_mem[1] <= i_data;
      end
      r_count <= r_count + 2'd1;
    end else if (w_pop) begin
      r_mem[0] <= r_mem[1];
      r_count  <= r_count - 2'd1;
    end
  end

  // The read sequencer reserves a slot before issuing a read, so a write
  // into a full FIFO without a matching pop means the accounting is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (srst)
    !(i_push && !w_pop && (r_count == 2'(DEPTH))));

endmodule

// File: rtl/sinerom_osc.sv
// -----------------------------------------------------------------------------
// sinerom_osc
// Phase-accumulator oscillator that reads the shared 1024x16 sine ROM,
// scales each sample by a Q1.15 amplitude and queues it in a 2-entry FIFO.
// Ports:
//   sys_clk, reset        : clock, synchronous active-high reset
//   en                    : run; dropping it stops new reads only
//   phase_inc             : phase step per fetched sample
//   phase_ld, phase_init  : load pulse and value for the phase accumulator
//   amp                   : signed Q1.15 amplitude, sampled at data capture
//   bus_req, bus_gnt      : shared-ROM arbitration
//   cs, a                 : ROM chip select (active low), address (a[0]=LSB)
//   z_in, z_oe            : ROM data and per-bit output enables (bit 0 = LSB)
//   smp, smp_valid        : FIFO head sample and non-empty flag
//   smp_ready             : consumer accept
//   err                   : sticky, ROM data invalid during a capture cycle
// -----------------------------------------------------------------------------
module sinerom_osc
  import sinerom_pkg::*;
#(
  parameter int PHW   = 22,
  parameter int DEPTH = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              en,
  input  logic [PHW-1:0]    phase_inc,
  input  logic              phase_ld,
  input  logic [PHW-1:0]    phase_init,
  input  logic [15:0]       amp,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              cs,
  output logic [0:ROM_AW-1] a,
  input  logic [0:ROM_DW-1] z_in,
  input  logic [0:ROM_DW-1] z_oe,
  output logic [15:0]       smp,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic              err
);

  state_t              r_state;
  state_t              w_state_next;
  logic [PHW-1:0]      r_phase;
  logic [ROM_AW-1:0]   w_addr;
  logic [ROM_DW-1:0]   w_z;
  logic [ROM_DW-1:0]   w_oe;
  logic                w_oe_ok;
  logic                w_grant;
  logic                w_capture;
  logic                w_bus_req;
  logic                w_slot_free;
  logic [1:0]          w_inflight;
  logic [2:0]          w_occupancy;
  logic [ROM_DW-1:0]   r_z;
  logic [15:0]         r_amp;
  logic                r_mul_vld;
  logic                r_err;
  logic signed [31:0]  w_prod;
  logic                w_sat;
  logic [15:0]         w_result;
  logic                w_unused_prod;
  logic [1:0]          w_fifo_count;
  logic                w_fifo_pop;

  // ROM buses are little-endian-indexed ([0:N] with bit 0 = LSB); map them
  // bit by bit onto conventional [N:0] vectors.
  assign w_addr = r_phase[PHW-1 -: ROM_AW];

  generate
    for (genvar gi = 0; gi < ROM_AW; gi++) begin : g_addr
      assign a[gi] = w_addr[gi];
    end
    for (genvar gi = 0; gi < ROM_DW; gi++) begin : g_data
      assign w_z[gi]  = z_in[gi];
      assign w_oe[gi] = z_oe[gi];
    end
  endgenerate

  assign w_oe_ok = (w_oe == OE_ALL);

  // Reads in flight: one being captured plus one in the multiply stage.
  assign w_inflight  = {1'b0, (r_state == CAP)} + {1'b0, r_mul_vld};
  // A slot popped on this edge is already free for the next read decision.
  assign w_occupancy = {1'b0, w_fifo_count} - {2'b00, w_fifo_pop} + {1'b0, w_inflight};
  assign w_slot_free = (w_occupancy < 3'd2);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    w_bus_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_slot_free) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        w_bus_req = 1'b1;
        if (!en) begin
          w_state_next = IDLE;
        end else if (bus_gnt) begin
          w_grant      = 1'b1;
          w_state_next = CAP;
        end
      end
      CAP: begin
        w_capture    = 1'b1;
        w_state_next = (en && w_slot_free) ? REQ : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // cs is combinational from the grant so it can never lead bus_gnt; reset
  // forces it inactive immediately.
  assign cs      = ~(w_grant && !reset);
  assign bus_req = w_bus_req;

  // phase_ld wins over the increment; the address already on the bus in the
  // grant cycle was taken from the old phase.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (phase_ld) begin
      r_phase <= phase_init;
    end else if (w_grant) begin
      r_phase <= r_phase + phase_inc;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_z       <= '0;
      r_amp     <= '0;
      r_mul_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mul_vld <= w_capture && w_oe_ok;
      if (w_capture && w_oe_ok) begin
        r_z   <= w_z;
        r_amp <= amp;
      end
      if (w_capture && !w_oe_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  // Q1.15 x Q1.15 -> Q1.15; only -1 * -1 overflows and is clamped.
  assign w_prod        = $signed(r_z) * $signed(r_amp);
  assign w_sat         = (r_z == 16'h8000) && (r_amp == 16'h8000);
  assign w_result      = w_sat ? 16'h7fff : w_prod[30:15];
  assign w_unused_prod = ^{w_prod[31], w_prod[14:0]};

  assign err = r_err;

  sinerom_osc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .srst    (reset),
    .i_push  (r_mul_vld),
    .i_data  (w_result),
    .i_ready (smp_ready),
    .o_data  (smp),
    .o_valid (smp_valid),
    .o_pop   (w_fifo_pop),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_sinerom_osc.sv
// -----------------------------------------------------------------------------
// tb_sinerom_osc
// Directed bench for sinerom_osc with a registered-read ROM model.
// -----------------------------------------------------------------------------
module tb_sinerom_osc;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] z;
    logic [15:0] amp;
    logic [15:0] exp_smp;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        reset, en, phase_ld, bus_gnt, smp_ready;
  logic        bus_req, cs, smp_valid, err;
  logic [21:0] phase_inc, phase_init;
  logic [15:0] amp, smp;
  logic [0:9]  a;
  logic [0:15] z_in, z_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] rom [1024];
  logic [15:0] rom_q   = '0;
  logic        rom_vld = 1'b0;
  logic        rom_bad = 1'b0;
  int          rd_num  = 0;
  int          bad_rd  = -1;
  logic [9:0]  a_val;

  int          addr_q[$];
  int          addr_cyc_q[$];
  logic [15:0] smp_q[$];

  vec_t vecs [9];

  always #5 sys_clk = ~sys_clk;

  sinerom_osc #(.PHW(22), .DEPTH(2)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .en         (en),
    .phase_inc  (phase_inc),
    .phase_ld   (phase_ld),
    .phase_init (phase_init),
    .amp        (amp),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .cs         (cs),
    .a          (a),
    .z_in       (z_in),
    .z_oe       (z_oe),
    .smp        (smp),
    .smp_valid  (smp_valid),
    .smp_ready  (smp_ready),
    .err        (err)
  );

  // ROM bus bit 0 is the LSB.
  always_comb begin
    a_val = '0;
    for (int i = 0; i < 10; i++) a_val[i] = a[i];
  end

  always_comb begin
    z_in = '0;
    z_oe = '0;
    for (int i = 0; i < 16; i++) begin
      z_in[i] = rom_vld ? rom_q[i] : 1'b0;
      z_oe[i] = rom_vld && !rom_bad;
    end
  end

  // ROM model: registered read, data valid the cycle after cs low.
  always @(posedge sys_clk) begin
    cyc     <= cyc + 1;
    rom_vld <= !cs;
    rom_q   <= rom[a_val];
    rom_bad <= !cs && (rd_num == bad_rd);
    if (!cs) rd_num <= rd_num + 1;
  end

  always @(negedge sys_clk) begin
    if (!reset) begin
      if (cs === 1'b0) begin
        addr_q.push_back(int'(a_val));
        addr_cyc_q.push_back(cyc);
      end
      if (smp_valid && smp_ready) smp_q.push_back(smp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end else begin
      $display("[TB] pass %s = %h", name, act);
    end
  endtask

  function automatic logic [15:0] exp_scale(input logic [15:0] z, input logic [15:0] g);
    int p;
    if (z == 16'h8000 && g == 16'h8000) return 16'h7fff;
    p = int'($signed(z)) * int'($signed(g));
    return 16'(p >>> 15);
  endfunction

  function automatic logic [31:0] qa(input int k);
    return (k < addr_q.size()) ? 32'(addr_q[k]) : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] qc(input int k);
    return (k < addr_cyc_q.size()) ? 32'(addr_cyc_q[k]) : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] qs(input int k);
    return (k < smp_q.size()) ? {16'h0, smp_q[k]} : 32'hffff_ffff;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input bit chk);
    reset      = 1'b1;
    en         = 1'b0;
    phase_ld   = 1'b0;
    bus_gnt    = 1'b0;
    smp_ready  = 1'b0;
    phase_inc  = '0;
    phase_init = '0;
    amp        = '0;
    step();
    step();
    if (chk) begin
      @(negedge sys_clk);
      check("rst_cs", {31'h0, cs}, 32'h1);
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_smp_valid", {31'h0, smp_valid}, 32'h0);
      check("rst_smp", {16'h0, smp}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_a", {22'h0, a_val}, 32'h0);
    end
    step();
    reset = 1'b0;
    addr_q.delete();
    addr_cyc_q.delete();
    smp_q.delete();
  endtask

  initial begin
    bit found;

    for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 1061) ^ 16'hA5C3;

    vecs[0] = '{10'h200, 16'h4000, 16'h4000, 16'h2000};
    vecs[1] = '{10'h201, 16'h8000, 16'h8000, 16'h7fff};
    vecs[2] = '{10'h202, 16'h7fff, 16'h7fff, 16'h7ffe};
    vecs[3] = '{10'h203, 16'h8000, 16'h7fff, 16'h8001};
    vecs[4] = '{10'h204, 16'h1234, 16'h8000, 16'hedcc};
    vecs[5] = '{10'h205, 16'hffff, 16'h7fff, 16'hffff};
    vecs[6] = '{10'h206, 16'h0001, 16'h7fff, 16'h0000};
    vecs[7] = '{10'h207, 16'h4000, 16'hc000, 16'he000};
    vecs[8] = '{10'h3ff, 16'h7fff, 16'h8000, 16'h8001};

    // Streaming: one read every 2 cycles, samples in order.
    do_reset(1'b1);
    en = 1'b1; bus_gnt = 1'b1; phase_inc = 22'h001000; amp = 16'h7fff; smp_ready = 1'b1;
    run(30);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_addr%0d", k), qa(k), 32'(k));
      check($sformatf("t1_smp%0d", k), qs(k), {16'h0, exp_scale(rom[k], 16'h7fff)});
      if (k > 0) check($sformatf("t1_gap%0d", k), qc(k) - qc(k - 1), 32'd2);
    end

    // Back-pressure: exactly two reads, then resume without loss.
    do_reset(1'b0);
    en = 1'b1; bus_gnt = 1'b1; phase_inc = 22'h001000; amp = 16'h7fff; smp_ready = 1'b0;
    run(16);
    @(negedge sys_clk);
    check("t2_reads", 32'(addr_q.size()), 32'd2);
    check("t2_bus_req", {31'h0, bus_req}, 32'h0);
    check("t2_cs", {31'h0, cs}, 32'h1);
    check("t2_valid", {31'h0, smp_valid}, 32'h1);
    check("t2_head", {16'h0, smp}, {16'h0, exp_scale(rom[0], 16'h7fff)});
    step();
    smp_ready = 1'b1;
    run(24);
    for (int k = 0; k < 6; k++)
      check($sformatf("t2_smp%0d", k), qs(k), {16'h0, exp_scale(rom[k], 16'h7fff)});

    // Grant withheld: request held, phase frozen, one pulse at held address.
    do_reset(1'b0);
    phase_ld = 1'b1; phase_init = 22'h155000;
    step();
    phase_ld = 1'b0; en = 1'b1; phase_inc = 22'h001000; smp_ready = 1'b1; amp = 16'h7fff;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check($sformatf("t3_hold%0d", k), {30'h0, bus_req, cs}, 32'h3);
      step();
    end
    bus_gnt = 1'b1;
    @(negedge sys_clk);
    check("t3_cs_pulse", {31'h0, cs}, 32'h0);
    check("t3_addr", {22'h0, a_val}, 32'h155);
    step();
    bus_gnt = 1'b0;
    @(negedge sys_clk);
    check("t3_cs_after", {31'h0, cs}, 32'h1);
    check("t3_reads", 32'(addr_q.size()), 32'd1);
    step();
    en = 1'b0;
    run(4);

    // Address wrap 1023 -> 0.
    do_reset(1'b0);
    phase_ld = 1'b1; phase_init = 22'h3ff000;
    step();
    phase_ld = 1'b0; en = 1'b1; bus_gnt = 1'b1; phase_inc = 22'h001000;
    smp_ready = 1'b1; amp = 16'h7fff;
    run(10);
    check("t4_addr0", qa(0), 32'd1023);
    check("t4_addr1", qa(1), 32'd0);
    check("t4_addr2", qa(2), 32'd1);

    // Invalid ROM data: sticky err, sample dropped, stream continues.
    do_reset(1'b0);
    bad_rd = rd_num;
    en = 1'b1; bus_gnt = 1'b1; phase_inc = 22'h001000; smp_ready = 1'b1; amp = 16'h7fff;
    @(negedge sys_clk);
    check("t5_err_before", {31'h0, err}, 32'h0);
    run(16);
    bad_rd = -1;
    check("t5_err", {31'h0, err}, 32'h1);
    check("t5_addr1", qa(1), 32'd1);
    check("t5_smp0", qs(0), {16'h0, exp_scale(rom[1], 16'h7fff)});
    check("t5_smp1", qs(1), {16'h0, exp_scale(rom[2], 16'h7fff)});
    run(6);
    check("t5_err_sticky", {31'h0, err}, 32'h1);

    // Scaling and saturation table.
    foreach (vecs[i]) begin
      do_reset(1'b0);
      rom[vecs[i].addr] = vecs[i].z;
      phase_ld = 1'b1; phase_init = {vecs[i].addr, 12'h000}; phase_inc = '0;
      step();
      phase_ld = 1'b0; en = 1'b1; bus_gnt = 1'b1; smp_ready = 1'b0; amp = vecs[i].amp;
      run(12);
      @(negedge sys_clk);
      check($sformatf("t6_valid%0d", i), {31'h0, smp_valid}, 32'h1);
      check($sformatf("t6_smp%0d", i), {16'h0, smp}, {16'h0, vecs[i].exp_smp});
    end

    // Reset during the capture cycle.
    do_reset(1'b0);
    en = 1'b1; bus_gnt = 1'b1; smp_ready = 1'b0; amp = 16'h7fff; phase_inc = 22'h001000;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (cs === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t7_cs_seen", {31'h0, found}, 32'h1);
    step();
    reset = 1'b1; en = 1'b0;
    step();
    @(negedge sys_clk);
    check("t7_valid", {31'h0, smp_valid}, 32'h0);
    check("t7_cs", {31'h0, cs}, 32'h1);
    step();
    reset = 1'b0;
    run(6);
    @(negedge sys_clk);
    check("t7_valid_late", {31'h0, smp_valid}, 32'h0);
    check("t7_err", {31'h0, err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
